// File: rtl/audio_seq_pkg.sv
// Shared types and defaults for the audio frame sequencer: FSM states,
// default frame geometry and the delay-counter width.
package audio_seq_pkg;

  localparam int DEF_LINES  = 64;
  localparam int DEF_LINE_W = 512;
  localparam int IDX_W      = $clog2(DEF_LINES);
  localparam int WAIT_W     = 16;

  typedef enum logic [2:0] {
    LOAD,
    START,
    WAIT,
    RD_ISSUE,
    RD_WAIT,
    OUT_HOLD
  } seq_state_e;

endpackage

// File: rtl/seq_wait_counter.sv
// Loadable down-counter; done is high while the count sits at zero.
// Shared by the processing wait and the readback latency wait.
module seq_wait_counter
  import audio_seq_pkg::*;
#(
  parameter int W = WAIT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)          cnt <= '0;
    else if (load)       cnt <= load_val;
    else if (cnt != '0)  cnt <= cnt - W'(1);
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/audio_frame_sequencer.sv
// Host-side frame initiator: loads LINES lines into the core, pulses start,
// waits PROC_WAIT cycles, then streams the result lines back out.
module audio_frame_sequencer
  import audio_seq_pkg::*;
#(
  parameter int  LINES     = DEF_LINES,
  parameter int  LINE_W    = DEF_LINE_W,
  parameter int  PROC_WAIT = 8192,
  parameter int  RD_LAT    = 1,
  localparam int IW        = $clog2(LINES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_data,
  output logic              proc_data_wr_en,
  output logic [IW-1:0]     proc_input_index,
  output logic [LINE_W-1:0] proc_data_in,
  output logic              proc_start,
  output logic [IW-1:0]     proc_output_index,
  input  logic [LINE_W-1:0] proc_data_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic [15:0]       frame_count
);

  localparam logic [IW-1:0]     LAST_IDX  = IW'(LINES - 1);
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(PROC_WAIT);
  // Counter runs to zero, so RD_WAIT lasts RD_LAT cycles when loaded with RD_LAT-1.
  localparam logic [WAIT_W-1:0] LAT_LOAD  = (RD_LAT == 0) ? '0 : WAIT_W'(RD_LAT - 1);

  seq_state_e        state, state_n;
  logic [IW-1:0]     wcnt, rcnt;
  logic              in_hs, out_hs, capture;
  logic              cnt_load, cnt_done;
  logic [WAIT_W-1:0] cnt_val;

  seq_wait_counter #(.W(WAIT_W)) u_wait (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done     (cnt_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    in_ready = (state == LOAD);
    busy     = (state != LOAD);
    in_hs    = in_ready && in_valid;
    out_hs   = (state == OUT_HOLD) && out_ready;
    capture  = 1'b0;
    cnt_load = 1'b0;
    cnt_val  = '0;
    case (state)
      LOAD:     if (in_hs && wcnt == LAST_IDX) state_n = START;
      START: begin
        cnt_load = 1'b1;
        cnt_val  = WAIT_LOAD;
        state_n  = WAIT;
      end
      // The pulse cycle plus PROC_WAIT further cycles are spent here.
      WAIT:     if (cnt_done) state_n = RD_ISSUE;
      RD_ISSUE: begin
        if (RD_LAT == 0) begin
          capture = 1'b1;
          state_n = OUT_HOLD;
        end else begin
          cnt_load = 1'b1;
          cnt_val  = LAT_LOAD;
          state_n  = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt_done) begin
          capture = 1'b1;
          state_n = OUT_HOLD;
        end
      end
      OUT_HOLD: if (out_hs) state_n = out_last ? LOAD : RD_ISSUE;
      default:  state_n = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wcnt              <= '0;
      rcnt              <= '0;
      proc_data_wr_en   <= 1'b0;
      proc_input_index  <= '0;
      proc_data_in      <= '0;
      proc_start        <= 1'b0;
      proc_output_index <= '0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
      out_data          <= '0;
      frame_count       <= '0;
    end else begin
      proc_data_wr_en <= in_hs;
      proc_start      <= (state == START);
      if (in_hs) begin
        proc_input_index <= wcnt;
        proc_data_in     <= in_data;
        wcnt             <= (wcnt == LAST_IDX) ? '0 : wcnt + IW'(1);
      end
      // Index is placed on the bus as RD_ISSUE is entered and held until the next issue.
      if (state == WAIT && cnt_done) proc_output_index <= rcnt;
      if (capture) begin
        out_data  <= proc_data_out;
        out_valid <= 1'b1;
        out_last  <= (rcnt == LAST_IDX);
      end else if (out_hs) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (out_last) begin
          rcnt        <= '0;
          wcnt        <= '0;
          frame_count <= frame_count + 16'd1;
        end else begin
          rcnt              <= rcnt + IW'(1);
          proc_output_index <= rcnt + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_audio_frame_sequencer.sv
// Directed bench: four frames (back-to-back, gapped, reset in WAIT, reload)
// against a core model that returns written lines inverted after one cycle.
module tb_audio_frame_sequencer;

  localparam int LINES = 64, LINE_W = 512, IW = 6, PROC_WAIT = 16, RD_LAT = 1;
  typedef logic [LINE_W-1:0] line_t;

  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  line_t in_data = '0;
  logic in_ready, proc_data_wr_en, proc_start, out_valid, out_last, busy;
  logic [IW-1:0] proc_input_index, proc_output_index;
  line_t proc_data_in, proc_data_out, out_data;
  logic [15:0] frame_count;

  int total = 0, bad = 0, cyc = 0;
  int start_cnt = 0, start_cyc = 0, wr_seen = 0, first_wr_cyc = 0, last_wr_cyc = 0;
  logic [IW+LINE_W-1:0] wr_q[$];
  logic [LINE_W:0]      out_q[$];
  logic [IW+LINE_W-1:0] wr_e;
  logic [LINE_W:0]      out_e;
  line_t mem [LINES];

  audio_frame_sequencer #(.LINES(LINES), .LINE_W(LINE_W), .PROC_WAIT(PROC_WAIT), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .proc_data_wr_en(proc_data_wr_en), .proc_input_index(proc_input_index),
    .proc_data_in(proc_data_in), .proc_start(proc_start), .proc_output_index(proc_output_index),
    .proc_data_out(proc_data_out), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy), .frame_count(frame_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (proc_data_wr_en) mem[proc_input_index] <= proc_data_in;
    proc_data_out <= ~mem[proc_output_index];
  end

  task automatic chk(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic line_t in_line(input int i, input int f);
    return {32{16'(i + 256 * f)}};
  endfunction

  // Write scoreboard and start-pulse bookkeeping
  always @(negedge clk) begin
    if (rst_n) begin
      if (proc_start) begin start_cnt++; start_cyc = cyc; end
      if (proc_data_wr_en) begin
        if (wr_seen % LINES == 0) first_wr_cyc = cyc;
        last_wr_cyc = cyc;
        wr_seen++;
        chk("wr_expected", (wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          wr_e = wr_q.pop_front();
          chk("wr_index", proc_input_index, wr_e[IW+LINE_W-1:LINE_W]);
          chk("wr_data", proc_data_in, wr_e[LINE_W-1:0]);
        end
      end
    end
  end

  // Output scoreboard: pop on each accepted line
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      chk("out_expected", (out_q.size() != 0), 1);
      if (out_q.size() != 0) begin
        out_e = out_q.pop_front();
        chk("out_data", out_data, out_e[LINE_W-1:0]);
        chk("out_last", out_last, out_e[LINE_W]);
      end
    end
  end

  task automatic load_frame(input int f, input bit gapped, input bit expect_out);
    int sb;
    sb = start_cnt;
    for (int i = 0; i < LINES; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_data  = in_line(i, f);
      wr_q.push_back({IW'(i), in_line(i, f)});
      if (expect_out) out_q.push_back({(i == LINES - 1), ~in_line(i, f)});
      if (i == 0 || i == LINES - 1) chk("in_ready_load", in_ready, 1);
      if (i == LINES - 1) chk("no_early_start", start_cnt, sb);
      if (gapped) begin @(posedge clk); #1; in_valid = 1'b0; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_after_load", in_ready, 0);
    chk("busy_after_load", busy, 1);
  endtask

  task automatic wait_start(output int p);
    int n;
    n = 0;
    @(negedge clk);
    while (!proc_start && n < 50) begin @(negedge clk); n++; end
    chk("start_seen", proc_start, 1);
    p = cyc;
  endtask

  task automatic wait_frames(input int fc);
    int n;
    n = 0;
    while (frame_count != 16'(fc) && n < 2000) begin @(negedge clk); n++; end
    chk("frame_count", frame_count, fc);
  endtask

  initial begin
    int p, n, stall_bad, win_bad, sc;
    line_t snap;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_wr_en", proc_data_wr_en, 0);
    chk("rst_start", proc_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_frame_count", frame_count, 0);
    chk("rst_out_index", proc_output_index, 0);
    chk("rst_in_index", proc_input_index, 0);
    chk("rst_data_in", proc_data_in, 0);
    chk("rst_out_data", out_data, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Frame 1: back-to-back load, stall on line 5
    out_ready = 1'b1;
    load_frame(0, 1'b0, 1'b1);
    wait_start(p);
    n = 0;
    while (!out_valid && n < 100) begin @(negedge clk); n++; end
    // Index on bus PROC_WAIT+1 after the pulse, data RD_LAT later, registered one more.
    chk("first_out_latency", cyc - p, 19);
    n = 0;
    while (!(proc_output_index == 5 && !out_valid) && n < 400) begin @(negedge clk); n++; end
    chk("reach_line5", proc_output_index, 5);
    @(posedge clk); #1 out_ready = 1'b0;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 20) begin @(negedge clk); n++; end
    chk("line5_valid", out_valid, 1);
    snap = out_data;
    stall_bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== snap || proc_output_index !== 6'd5) stall_bad++;
    end
    chk("stall_stable", stall_bad, 0);
    @(posedge clk); #1 out_ready = 1'b1;
    wait_frames(1);
    @(negedge clk);
    chk("f1_out_q_empty", out_q.size(), 0);
    chk("f1_wr_q_empty", wr_q.size(), 0);
    chk("f1_writes", wr_seen, 64);
    chk("f1_write_span", last_wr_cyc - first_wr_cyc, 63);
    chk("f1_start_after_last_write", start_cyc - last_wr_cyc, 1);
    chk("f1_start_once", start_cnt, 1);
    chk("f1_idle_in_ready", in_ready, 1);
    chk("f1_idle_busy", busy, 0);

    // Frame 2: gapped load, index held at 63 through WAIT
    load_frame(1, 1'b1, 1'b1);
    wait_start(p);
    win_bad = 0;
    for (int k = 1; k <= PROC_WAIT; k++) begin
      @(negedge clk);
      if (proc_output_index !== 6'd63 || out_valid !== 1'b0) win_bad++;
    end
    chk("wait_window_quiet", win_bad, 0);
    @(negedge clk);
    chk("index0_at_p17", proc_output_index, 0);
    wait_frames(2);
    @(negedge clk);
    chk("f2_out_q_empty", out_q.size(), 0);
    chk("f2_writes", wr_seen, 128);
    chk("f2_start_count", start_cnt, 2);

    // Frame 3: reset during WAIT abandons the frame
    load_frame(2, 1'b0, 1'b0);
    wait_start(p);
    repeat (5) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("wrst_in_ready", in_ready, 1);
    chk("wrst_busy", busy, 0);
    chk("wrst_frame_count", frame_count, 0);
    sc = start_cnt;
    stall_bad = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || proc_data_wr_en !== 1'b0) stall_bad++;
    end
    chk("wrst_quiet", stall_bad, 0);
    chk("wrst_no_start", start_cnt, sc);

    // Frame 4: fresh load after reset
    load_frame(3, 1'b0, 1'b1);
    wait_frames(1);
    @(negedge clk);
    chk("f4_out_q_empty", out_q.size(), 0);
    chk("f4_wr_q_empty", wr_q.size(), 0);
    chk("f4_start_count", start_cnt, sc + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
